// File: rtl/os_inst_sequencer.sv
// Output-stationary instruction sequencer.
// For each input channel it fetches activations into L0 and weights into L1,
// streams one execute pass, and lets the array flush. After the last channel
// it recalls the partial sums and drains COL output rows from the OFIFO into
// psum memory. Every instruction bit is registered, so the word on inst
// describes the state the sequencer held during the previous cycle.
`timescale 1ns/1ps

module os_inst_sequencer #(
    parameter int ROW       = 8,
    parameter int COL       = 8,
    parameter int KIJ       = 9,
    parameter int NUM_IC    = 8,
    parameter int ACT_BASE  = 0,
    parameter int WGT_BASE  = 576,
    parameter int PMEM_BASE = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        ofifo_valid,
    output logic [63:0] inst,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE, L0, L1, EXEC, FLUSH, RECALL, DRAIN, DONE
    } state_t;

    // Phase counter must reach KIJ (fetch/exec) and ROW+COL-1 (flush).
    localparam int CNT_MAX = (KIJ + 1 > ROW + COL) ? KIJ + 1 : ROW + COL;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int ICW     = $clog2(NUM_IC + 1);
    localparam int DW      = $clog2(COL + 1);

    // Bit positions inside the instruction word.
    localparam int B_EXECUTE  = 1;
    localparam int B_L0_WR    = 2;
    localparam int B_L0_RD    = 3;
    localparam int B_OFIFO_RD = 6;
    localparam int B_WEN_X    = 18;
    localparam int B_CEN_X    = 19;
    localparam int B_WEN_P    = 31;
    localparam int B_CEN_P    = 32;
    localparam int B_SFU_PASS = 34;
    localparam int B_L1_WR    = 37;
    localparam int B_RECALL   = 38;
    localparam int B_PASS_PS  = 39;

    // Both memories deselected and write-disabled, output_stationary set.
    localparam logic [39:0] IDLE_WORD = 40'h11_800C_0000;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg,   cnt_next;
    logic [ICW-1:0]  ic_reg,    ic_next;
    logic [DW-1:0]   d_reg,     d_next;
    logic            hold_reg,  hold_next;
    logic [39:0]     word_reg,  word_next;
    logic            done_reg,  done_next;

    logic [10:0]     act_addr;
    logic [10:0]     wgt_addr;
    logic [10:0]     pmem_addr;

    // 11-bit addresses wrap naturally; no saturation.
    assign act_addr  = 11'(ACT_BASE) + 11'(ic_reg) * 11'(KIJ) + 11'(cnt_reg);
    assign wgt_addr  = 11'(WGT_BASE) + 11'(ic_reg) * 11'(KIJ) + 11'(cnt_reg);
    assign pmem_addr = 11'(PMEM_BASE) + 11'(COL - 1) - 11'(d_reg);

    // State, counters and registered instruction/done outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            ic_reg    <= '0;
            d_reg     <= '0;
            hold_reg  <= 1'b0;
            word_reg  <= IDLE_WORD;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ic_reg    <= ic_next;
            d_reg     <= d_next;
            hold_reg  <= hold_next;
            word_reg  <= word_next;
            done_reg  <= done_next;
        end
    end

    // Next-state, counter updates and the instruction for the current state.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ic_next    = ic_reg;
        d_next     = d_reg;
        // A start still high after DONE must be released before it counts again.
        hold_next  = hold_reg && start;
        word_next  = IDLE_WORD;
        done_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start && !hold_reg) begin
                    state_next = L0;
                    cnt_next   = '0;
                    ic_next    = '0;
                    d_next     = '0;
                end
            end
            L0, L1: begin
                // SRAM reads on cycles 0..KIJ-1, buffer writes one cycle later.
                if (cnt_reg < CW'(KIJ)) begin
                    word_next[B_CEN_X] = 1'b0;
                    word_next[17:7]    = (state_reg == L0) ? act_addr : wgt_addr;
                end
                if (cnt_reg != '0) begin
                    if (state_reg == L0) word_next[B_L0_WR] = 1'b1;
                    else                 word_next[B_L1_WR] = 1'b1;
                end
                if (cnt_reg == CW'(KIJ)) begin
                    cnt_next   = '0;
                    state_next = (state_reg == L0) ? L1 : EXEC;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            EXEC: begin
                // First read primes the L0 output; execute follows a cycle later.
                word_next[B_L0_RD] = 1'b1;
                if (cnt_reg != '0) word_next[B_EXECUTE] = 1'b1;
                if (cnt_reg == CW'(KIJ)) begin
                    cnt_next   = '0;
                    state_next = FLUSH;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            FLUSH: begin
                if (cnt_reg == CW'(ROW + COL - 1)) begin
                    cnt_next = '0;
                    if (ic_reg < ICW'(NUM_IC - 1)) begin
                        ic_next    = ic_reg + ICW'(1);
                        state_next = L0;
                    end else begin
                        state_next = RECALL;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            RECALL: begin
                word_next[B_RECALL]   = 1'b1;
                word_next[B_SFU_PASS] = 1'b1;
                d_next                = '0;
                state_next            = DRAIN;
            end
            DRAIN: begin
                word_next[B_SFU_PASS] = 1'b1;
                // Rows are written bottom-up; stalls hold d and keep pmem off.
                if (ofifo_valid) begin
                    word_next[B_OFIFO_RD] = 1'b1;
                    word_next[B_PASS_PS]  = 1'b1;
                    word_next[B_CEN_P]    = 1'b0;
                    word_next[B_WEN_P]    = 1'b0;
                    word_next[30:20]      = pmem_addr;
                    if (d_reg == DW'(COL - 1)) begin
                        d_next     = '0;
                        state_next = DONE;
                    end else begin
                        d_next = d_reg + DW'(1);
                    end
                end
            end
            DONE: begin
                done_next  = 1'b1;
                hold_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // Abort wins over everything once a sequence is running.
        if (abort && state_reg != IDLE) begin
            state_next = IDLE;
            cnt_next   = '0;
            ic_next    = '0;
            d_next     = '0;
            hold_next  = hold_reg && start;
            word_next  = IDLE_WORD;
            done_next  = 1'b0;
        end
    end

    assign inst[39:0] = word_reg;
    assign busy       = (state_reg != IDLE);
    assign done       = done_reg;

    // Upper instruction bits are reserved and tied low.
    genvar gi;
    generate
        for (gi = 40; gi < 64; gi++) begin : g_rsvd
            assign inst[gi] = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_os_inst_sequencer.sv
// Bench for os_inst_sequencer: a position-based model of the instruction
// stream is compared with the DUT every cycle, plus directed literal checks.
`timescale 1ns/1ps

module tb_os_inst_sequencer;

    localparam int ROW = 8, COL = 8, KIJ = 9, NUM_IC = 8;
    localparam int ACT_BASE = 0, WGT_BASE = 576, PMEM_BASE = 0;
    localparam int P    = 3 * KIJ + 3 + ROW + COL;   // cycles per input channel
    localparam int PRE  = NUM_IC * P + 1;            // cycles before the drain
    localparam int MAXC = 512;
    localparam logic [63:0] IDLE_LIT = 64'h0000_0011_800C_0000;

    localparam int M_PLAIN = 0, M_STALL = 1, M_HOLD = 2, M_RAND = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        ofifo_valid = 1'b0;
    logic [63:0] inst;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] tr_inst [0:MAXC-1];
    logic        tr_busy [0:MAXC-1];
    logic        tr_done [0:MAXC-1];

    // model state
    logic [63:0] exp_inst = IDLE_LIT;
    logic        exp_busy = 1'b0;
    logic        exp_done = 1'b0;
    logic        m_active = 1'b0;
    logic        m_armed  = 1'b1;
    logic        m_block  = 1'b0;
    int          m_t = 0;
    int          m_d = 0;

    os_inst_sequencer #(
        .ROW(ROW), .COL(COL), .KIJ(KIJ), .NUM_IC(NUM_IC),
        .ACT_BASE(ACT_BASE), .WGT_BASE(WGT_BASE), .PMEM_BASE(PMEM_BASE)
    ) dut (
        .clk(clk),
        .reset(rst_n),
        .start(start),
        .abort(abort),
        .ofifo_valid(ofifo_valid),
        .inst(inst),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Word for position t of the pre-drain schedule (t counted from the start edge).
    function automatic logic [63:0] sched_word(input int t);
        logic [63:0] w;
        int ic, r, k;
        w = IDLE_LIT;
        if (t == NUM_IC * P) begin
            w[38] = 1'b1;
            w[34] = 1'b1;
            return w;
        end
        ic = t / P;
        r  = t % P;
        if (r < 2 * (KIJ + 1)) begin
            k = r % (KIJ + 1);
            if (k < KIJ) begin
                w[19]   = 1'b0;
                w[17:7] = 11'(((r < KIJ + 1) ? ACT_BASE : WGT_BASE) + ic * KIJ + k);
            end
            if (k > 0) begin
                if (r < KIJ + 1) w[2] = 1'b1;
                else             w[37] = 1'b1;
            end
        end else if (r < 3 * (KIJ + 1)) begin
            w[3] = 1'b1;
            if (r > 2 * (KIJ + 1)) w[1] = 1'b1;
        end
        return w;
    endfunction

    function automatic logic [63:0] drain_word(input logic v, input int d);
        logic [63:0] w;
        w = IDLE_LIT;
        w[34] = 1'b1;
        if (v) begin
            w[6]     = 1'b1;
            w[39]    = 1'b1;
            w[32]    = 1'b0;
            w[31]    = 1'b0;
            w[30:20] = 11'(PMEM_BASE + COL - 1 - d);
        end
        return w;
    endfunction

    // Model: what the outputs must show after each edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_armed  = 1'b1;
            exp_inst = IDLE_LIT;
            exp_busy = 1'b0;
            exp_done = 1'b0;
        end else begin
            exp_inst = IDLE_LIT;
            exp_done = 1'b0;
            m_block  = 1'b0;
            if (!m_active) begin
                if (start && m_armed) begin
                    m_active = 1'b1;
                    m_t = 0;
                    m_d = 0;
                end
            end else if (abort) begin
                m_active = 1'b0;
            end else if (m_t < PRE) begin
                exp_inst = sched_word(m_t);
                m_t++;
            end else if (m_d < COL) begin
                exp_inst = drain_word(ofifo_valid, m_d);
                if (ofifo_valid) m_d++;
            end else begin
                exp_done = 1'b1;
                m_active = 1'b0;
                m_block  = 1'b1;
            end
            if (m_block)     m_armed = 1'b0;
            else if (!start) m_armed = 1'b1;
            exp_busy = m_active;
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        chk("inst_vs_model", inst, exp_inst);
        chk("busy_vs_model", 64'(busy), 64'(exp_busy));
        chk("done_vs_model", 64'(done), 64'(exp_done));
    end

    // One sequence: start before edge 0, inputs for state cycle i driven after sample i.
    task automatic run_seq(input int mode, input int limit, input int abort_at,
                           output int first_done, output int n_done);
        first_done = -1;
        n_done     = 0;
        @(negedge clk);
        start = 1'b1; abort = 1'b0; ofifo_valid = 1'b1;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk);
            #1;
            tr_inst[i] = inst;
            tr_busy[i] = busy;
            tr_done[i] = done;
            if (done) begin
                n_done++;
                if (first_done < 0) first_done = i;
            end
            @(negedge clk);
            case (mode)
                M_HOLD:  start = (i < 382);
                M_RAND:  start = ($urandom_range(0, 15) == 0);
                default: start = 1'b0;
            endcase
            abort = (i == abort_at);
            case (mode)
                M_STALL: ofifo_valid = !((i >= PRE && i < PRE + 5) || (i >= PRE + 8 && i < PRE + 10));
                M_RAND:  ofifo_valid = ($urandom_range(0, 2) != 0);
                default: ofifo_valid = 1'b1;
            endcase
        end
        @(negedge clk);
        start = 1'b0; abort = 1'b1; ofifo_valid = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        $display("run mode=%0d cycles=%0d first_done=%0d dones=%0d", mode, limit, first_done, n_done);
    endtask

    initial begin
        int fd, nd, cnt_l0, cnt_ex, j;
        repeat (3) @(negedge clk);
        chk("reset_inst", inst, IDLE_LIT);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // pin the model with hand-computed words
        chk("model_l0_cyc0", sched_word(0), 64'h0000_0011_8004_0000);
        chk("model_l0_cyc1", sched_word(1), 64'h0000_0011_8004_0084);
        chk("model_recall",  sched_word(NUM_IC * P), 64'h0000_0055_800C_0000);
        chk("model_drain0",  drain_word(1'b1, 0), 64'h0000_0094_007C_0040);

        // default run, ofifo_valid held high
        run_seq(M_PLAIN, 400, -1, fd, nd);
        chk("done_latency", 64'(fd), 64'd378);
        chk("done_count", 64'(nd), 64'd1);
        cnt_l0 = 0; cnt_ex = 0;
        for (int i = 0; i < 400; i++) begin
            if (tr_inst[i][2]) cnt_l0++;
            if (tr_inst[i][1]) cnt_ex++;
        end
        chk("l0_wr_total", 64'(cnt_l0), 64'd72);
        chk("execute_total", 64'(cnt_ex), 64'd72);
        chk("busy_before_done", 64'(tr_busy[377]), 64'd1);
        chk("busy_at_done", 64'(tr_busy[378]), 64'd0);
        chk("ic3_l0_wr_cyc0", 64'(tr_inst[139][2]), 64'd0);
        for (int k = 0; k < 9; k++) begin
            chk("ic3_l0_addr", 64'(tr_inst[139 + k][17:7]), 64'(27 + k));
            chk("ic3_l0_wr", 64'(tr_inst[140 + k][2]), 64'd1);
            chk("ic3_l1_addr", 64'(tr_inst[149 + k][17:7]), 64'(603 + k));
        end

        // drain stalls: 5 at entry, 2 after the third transfer
        run_seq(M_STALL, 400, -1, fd, nd);
        chk("stall_done_latency", 64'(fd), 64'd385);
        j = 0;
        for (int i = PRE + 1; i <= PRE + 16; i++) begin
            if (tr_inst[i][6]) begin
                chk("pmem_addr_seq", 64'(tr_inst[i][30:20]), 64'(7 - j));
                j++;
            end
        end
        chk("pmem_transfers", 64'(j), 64'd8);
        for (int i = PRE + 1; i <= PRE + 10; i++) begin
            if (i <= PRE + 5 || i >= PRE + 9) begin
                chk("stall_cen_pmem", 64'(tr_inst[i][32]), 64'd1);
                chk("stall_ofifo_rd", 64'(tr_inst[i][6]), 64'd0);
            end
        end

        // abort during EXEC of ic=2
        run_seq(M_PLAIN, 130, 2 * P + 2 * (KIJ + 1) + 3, fd, nd);
        chk("abort_idle_word", tr_inst[2 * P + 2 * (KIJ + 1) + 4], IDLE_LIT);
        chk("abort_busy", 64'(tr_busy[2 * P + 2 * (KIJ + 1) + 4]), 64'd0);
        chk("abort_no_done", 64'(nd), 64'd0);
        run_seq(M_PLAIN, 3, -1, fd, nd);
        chk("restart_addr", 64'(tr_inst[1][17:7]), 64'd0);
        chk("restart_cen", 64'(tr_inst[1][19]), 64'd0);

        // start held high through DONE
        run_seq(M_HOLD, 400, -1, fd, nd);
        chk("hold_done_count", 64'(nd), 64'd1);
        chk("hold_done_latency", 64'(fd), 64'd378);
        for (int i = 379; i < 400; i++) chk("hold_no_restart", 64'(tr_busy[i]), 64'd0);

        // asynchronous reset in L0 and in FLUSH
        for (int r = 0; r < 2; r++) begin
            @(negedge clk); start = 1'b1;
            @(negedge clk); start = 1'b0;
            repeat ((r == 0) ? 5 : 35) @(posedge clk);
            #3 rst_n = 1'b0;
            #1;
            chk("async_rst_inst", inst, IDLE_LIT);
            chk("async_rst_busy", 64'(busy), 64'd0);
            chk("async_rst_done", 64'(done), 64'd0);
            @(negedge clk); @(negedge clk);
            rst_n = 1'b1;
            j = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (done || busy) j++;
            end
            chk("post_reset_quiet", 64'(j), 64'd0);
            $display("async reset case %0d done", r);
        end

        // randomized traffic, occasionally aborted
        for (int r = 0; r < 6; r++) begin
            run_seq(M_RAND, 420, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 400)) : -1, fd, nd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/os_inst_sequencer.md
OS_INST_SEQUENCER -- requirements
Module: os_inst_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- ROW, 8, PE array rows.
- COL, 8, PE array columns and output rows drained.
- KIJ, 9, kernel taps per input channel.
- NUM_IC, 8, input channels, minimum 1.
- ACT_BASE, 0, xmem activation base address.
- WGT_BASE, 576, xmem weight base address.
- PMEM_BASE, 0, psum SRAM base address.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge.
- reset, in, 1, asynchronous, active-low.
- start, in, 1, begin one output-stationary tile.
- abort, in, 1, synchronous cancel.
- ofifo_valid, in, 1, OFIFO holds a readable row.
- inst, out, 64, core instruction word.
- busy, out, 1, sequence in progress.
- done, out, 1, one-cycle completion pulse.
REQ-003 inst SHALL use this field map:
- [0] load, [1] execute, [2] l0_wr, [3] l0_rd, [4] ififo_rd, [5] ififo_wr, [6] ofifo_rd.
- [17:7] A_xmem, [18] WEN_xmem, [19] CEN_xmem.
- [30:20] A_pmem, [31] WEN_pmem, [32] CEN_pmem.
- [33] acc, [34] sfu_passthrough, [35] REN_pmem, [36] output_stationary, [37] l1_wr, [38] recall_psum, [39] pass_psum.
- [63:40] SHALL be 0.
REQ-004 Bits [0], [4], [5], [33], [35] and [63:40] SHALL be held at 0; bit [36] SHALL be held at 1.

Function
REQ-005 The idle word SHALL have CEN_xmem=WEN_xmem=CEN_pmem=WEN_pmem=1, bit [36]=1, and every other bit 0.
REQ-006 The FSM states SHALL be IDLE, L0, L1, EXEC, FLUSH, RECALL, DRAIN, DONE.
REQ-007 In IDLE with start=1, the FSM SHALL clear ic to 0 and enter L0; busy SHALL be 1 in every state except IDLE.
REQ-008 L0 SHALL last KIJ+1 cycles:
- Cycles 0..KIJ-1: CEN_xmem=0, WEN_xmem=1, A_xmem=ACT_BASE+ic*KIJ+k.
- Cycles 1..KIJ: l0_wr=1, covering the one-cycle SRAM read latency.
REQ-009 L1 SHALL be identical to L0 except the base is WGT_BASE and l1_wr replaces l0_wr.
REQ-010 EXEC SHALL last KIJ+1 cycles:
- Cycle 0: l0_rd=1 only.
- Cycles 1..KIJ: l0_rd=1 and execute=1.
REQ-011 FLUSH SHALL hold the idle word for ROW+COL cycles.
- At the end of FLUSH, if ic<NUM_IC-1, the FSM SHALL increment ic and enter L0.
- Otherwise it SHALL enter RECALL.
REQ-012 RECALL SHALL last 1 cycle with recall_psum=1 and sfu_passthrough=1.
REQ-013 DRAIN SHALL hold sfu_passthrough=1 throughout and issue COL transfer cycles, counted by d=0..COL-1.
- A transfer cycle occurs only when ofifo_valid=1.
- In a transfer cycle: ofifo_rd=1, pass_psum=1, CEN_pmem=0, WEN_pmem=0, A_pmem=PMEM_BASE+COL-1-d.
REQ-014 A DRAIN cycle with ofifo_valid=0 SHALL present ofifo_rd=0, pass_psum=0 and CEN_pmem=1, and SHALL hold d; this applies whether it falls before the first transfer or between transfers.
REQ-015 After the COL-th transfer, the FSM SHALL enter DONE.
- DONE lasts 1 cycle with done=1 and the idle word, then returns to IDLE.
REQ-016 start SHALL be ignored outside IDLE; a start arriving in the DONE cycle SHALL be dropped.
REQ-017 abort=1 in any non-IDLE state SHALL force IDLE at the next edge, with the idle word, busy=0 and no done pulse.
- abort has priority over start and over every state transition.
REQ-018 All inst fields SHALL be registered outputs of the FSM and counters, with no combinational path from any input to inst.
REQ-019 Address arithmetic SHALL be 11-bit unsigned with wrap-around; no saturation is applied.
REQ-020 Latency with ofifo_valid held at 1:
- done SHALL assert exactly NUM_IC*(3*KIJ+3+ROW+COL)+COL+2 cycles after the edge that samples start.
- With the defaults this is 378 cycles.

Reset
REQ-021 While reset=0, the block SHALL asynchronously force state=IDLE, ic=0, d=0, busy=0, done=0, and inst equal to the idle word.
REQ-022 Deassertion of reset SHALL take effect at the next clk edge.
REQ-023 reset asserted mid-sequence SHALL discard all progress, and no done pulse SHALL follow.

Verification
REQ-024 Defaults, start pulse, ofifo_valid=1:
- done occurs at cycle 378.
- l0_wr is high on exactly 72 cycles total, and execute is high on exactly 72 cycles total.
- busy falls together with the done pulse.
REQ-025 ic=3, L0 phase:
- A_xmem steps 27..35 on cycles 0..8.
- l0_wr is high on cycles 1..9.
- In L1 the same cycles carry A_xmem 603..611.
REQ-026 ofifo_valid=0 for 5 cycles at DRAIN entry, then high, with a 2-cycle drop after the 3rd transfer:
- A_pmem sequence is 7,6,5,4,3,2,1,0.
- CEN_pmem=1 during every stall cycle.
- done is delayed by exactly 7 cycles.
REQ-027 abort during EXEC of ic=2:
- The next cycle shows the idle word and busy=0, with no done.
- A subsequent start restarts at A_xmem=0.
REQ-028 reset driven low mid-FLUSH, asynchronously between edges: inst equals the idle word immediately, before the next edge.
REQ-029 start held high through DONE: exactly one sequence runs, with no back-to-back restart.
